// File: rtl/wallace_mac_if.sv
// Handshake bundle for wallace_mac: operand stream in, accumulated result out.
interface wallace_mac_if #(
  parameter int unsigned ACC_W = 24,
  parameter int unsigned CNT_W = 8
) ();
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       a;
  logic [7:0]       b;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  modport master (
    output in_valid, a, b, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf
  );

  modport slave (
    input  in_valid, a, b, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf
  );
endinterface

// File: rtl/wallace_mac.sv
// Pipelined multiply-accumulate behind an 8x8 Wallace-tree multiplier.
// Optional WALLACE_MAC_SATURATE_EN clamps the sum on overflow instead of wrapping.
module wallace_mac #(
  parameter int unsigned ACC_W = 24,
  parameter int unsigned CNT_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  wallace_mac_if.slave  bus
);
  localparam int unsigned SUM_W = ACC_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             w_adv;
  logic             r_s1_v;
  logic             r_s1_last;
  logic [7:0]       r_s1_a;
  logic [7:0]       r_s1_b;
  logic [15:0]      w_asn;
  logic             r_s2_v;
  logic             r_s2_last;
  logic [15:0]      r_s2_p;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic [SUM_W-1:0] w_nxt;
  logic             w_carry;
  logic [ACC_W-1:0] w_acc_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_done;
  logic             r_out_valid;
  logic [ACC_W-1:0] r_out_sum;
  logic [CNT_W-1:0] r_out_count;
  logic             r_out_ovf;

  // Whole pipeline moves in lockstep; only a held, unconsumed result stalls it.
  assign w_adv        = !r_out_valid || bus.out_ready;
  assign bus.in_ready = w_adv;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_v    <= 1'b0;
      r_s1_last <= 1'b0;
      r_s1_a    <= 8'd0;
      r_s1_b    <= 8'd0;
    end else if (w_adv) begin
      r_s1_v <= bus.in_valid;
      if (bus.in_valid) begin
        r_s1_a    <= bus.a;
        r_s1_b    <= bus.b;
        r_s1_last <= bus.in_last;
      end
    end
  end

  wallace u_wallace (
    .a   (r_s1_a),
    .b   (r_s1_b),
    .asn (w_asn)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_v    <= 1'b0;
      r_s2_last <= 1'b0;
      r_s2_p    <= 16'd0;
    end else if (w_adv) begin
      r_s2_v    <= r_s1_v;
      r_s2_last <= r_s1_last;
      r_s2_p    <= w_asn;
    end
  end

  assign w_nxt     = SUM_W'(r_acc) + SUM_W'(r_s2_p);
  assign w_carry   = w_nxt[ACC_W];
  assign w_cnt_nxt = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_done    = r_s2_v && r_s2_last;

`ifdef WALLACE_MAC_SATURATE_EN
  assign w_acc_nxt = w_carry ? {ACC_W{1'b1}} : w_nxt[ACC_W-1:0];
`else
  assign w_acc_nxt = w_nxt[ACC_W-1:0];
`endif

  // Completion loads the result and restarts the accumulator on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_count <= '0;
      r_out_ovf   <= 1'b0;
    end else if (w_adv) begin
      r_out_valid <= w_done;
      if (w_done) begin
        r_out_sum   <= w_acc_nxt;
        r_out_count <= w_cnt_nxt;
        r_out_ovf   <= r_ovf | w_carry;
        r_acc       <= '0;
        r_cnt       <= '0;
        r_ovf       <= 1'b0;
      end else if (r_s2_v) begin
        r_acc <= w_acc_nxt;
        r_cnt <= w_cnt_nxt;
        r_ovf <= r_ovf | w_carry;
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_sum   = r_out_sum;
  assign bus.out_count = r_out_count;
  assign bus.out_ovf   = r_out_ovf;
endmodule

// 8x8 unsigned multiplier: eight partial products folded by a 3:2 carry-save tree.
module wallace (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] asn
);
  logic [15:0] w_pp [8];
  logic [15:0] w_s0, w_c0, w_s1, w_c1, w_s2, w_c2;
  logic [15:0] w_s3, w_c3, w_s4, w_c4, w_s5, w_c5;

  function automatic logic [15:0] csa_s(input logic [15:0] x, input logic [15:0] y,
                                        input logic [15:0] z);
    return x ^ y ^ z;
  endfunction

  function automatic logic [15:0] csa_c(input logic [15:0] x, input logic [15:0] y,
                                        input logic [15:0] z);
    return ((x & y) | (x & z) | (y & z)) << 1;
  endfunction

  for (genvar gi = 0; gi < 8; gi++) begin : g_pp
    assign w_pp[gi] = b[gi] ? (16'(a) << gi) : 16'd0;
  end

  // Level 1: 8 -> 6 rows
  assign w_s0 = csa_s(w_pp[0], w_pp[1], w_pp[2]);
  assign w_c0 = csa_c(w_pp[0], w_pp[1], w_pp[2]);
  assign w_s1 = csa_s(w_pp[3], w_pp[4], w_pp[5]);
  assign w_c1 = csa_c(w_pp[3], w_pp[4], w_pp[5]);
  // Level 2: 6 -> 4 rows
  assign w_s2 = csa_s(w_s0, w_c0, w_s1);
  assign w_c2 = csa_c(w_s0, w_c0, w_s1);
  assign w_s3 = csa_s(w_c1, w_pp[6], w_pp[7]);
  assign w_c3 = csa_c(w_c1, w_pp[6], w_pp[7]);
  // Level 3: 4 -> 3 rows, level 4: 3 -> 2 rows
  assign w_s4 = csa_s(w_s2, w_c2, w_s3);
  assign w_c4 = csa_c(w_s2, w_c2, w_s3);
  assign w_s5 = csa_s(w_s4, w_c4, w_c3);
  assign w_c5 = csa_c(w_s4, w_c4, w_c3);

  assign asn = w_s5 + w_c5;
endmodule

// File: tb/tb_wallace_mac.sv
// Scoreboard bench for wallace_mac: driver feeds a vector-sum model, monitor checks outputs.
module tb_wallace_mac;
  localparam int unsigned ACC_W   = 16;
  localparam int unsigned CNT_W   = 4;
  localparam longint      ACC_MAX = (longint'(1) << ACC_W) - 1;
  localparam longint      CNT_MAX = (longint'(1) << CNT_W) - 1;
`ifdef WALLACE_MAC_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    longint sum;
    longint cnt;
    bit     ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t q[$];

  longint m_sum = 0;
  longint m_cnt = 0;
  bit     m_ovf = 1'b0;

  bit     rdy_mode = 1'b0;
  bit     rdy_val  = 1'b1;

  wallace_mac_if #(.ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

  wallace_mac #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Vector-sum reference: unbounded sum, then wrap or clamp at the accumulator width.
  task automatic model_beat(input int unsigned av, input int unsigned bv, input bit lst);
    longint s;
    exp_t   e;
    s = m_sum + longint'(av) * longint'(bv);
    if (s > ACC_MAX) begin
      m_ovf = 1'b1;
      s = SAT ? ACC_MAX : s - (ACC_MAX + 1);
    end
    m_sum = s;
    if (m_cnt < CNT_MAX) m_cnt++;
    if (lst) begin
      e.sum = m_sum; e.cnt = m_cnt; e.ovf = m_ovf;
      q.push_back(e);
      m_sum = 0; m_cnt = 0; m_ovf = 1'b0;
    end
  endtask

  task automatic send(input int unsigned av, input int unsigned bv, input bit lst);
    bit rdy;
    int waits;
    waits = 0;
    bus.in_valid = 1'b1;
    bus.a        = 8'(av);
    bus.b        = 8'(bv);
    bus.in_last  = lst;
    do begin
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk);
      waits++;
    end while (!rdy && waits < 500);
    #1;
    if (rdy) model_beat(av, bv, lst);
    else begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: beat %0dx%0d not accepted in %0d cycles", av, bv, waits);
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic set_ready(input bit v);
    rdy_mode = 1'b0;
    rdy_val  = v;
    @(posedge clk); #2;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      @(posedge clk); n++;
    end
    repeat (3) @(posedge clk);
    #1;
    check(name, q.size(), 0);
  endtask

  // Sole driver of out_ready: forced value or random backpressure.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.out_ready = rdy_mode ? ($urandom_range(0, 99) < 70) : rdy_val;
    end
  end

  // Monitor: every transfer pops the oldest expected result.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_result: got sum %0d count %0d with nothing expected",
                 bus.out_sum, bus.out_count);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("out_sum", longint'(bus.out_sum), e.sum);
        check("out_count", longint'(bus.out_count), e.cnt);
        check("out_ovf", longint'(bus.out_ovf), longint'(e.ovf));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.a = 8'd0; bus.b = 8'd0; bus.in_last = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_sum", bus.out_sum, 0);
    check("rst_out_count", bus.out_count, 0);
    check("rst_out_ovf", bus.out_ovf, 0);
    check("rst_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;

    // Single term and latency
    send(255, 255, 1);
    k = cyc;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("lat_valid_%0d", cyc - k), bus.out_valid, (i == 2) ? 1 : 0);
      if (i == 2) begin
        check("single_sum", bus.out_sum, 65025);
        check("single_count", bus.out_count, 1);
        check("single_ovf", bus.out_ovf, 0);
      end
    end
    @(posedge clk); #1;
    wait_drain("drain_single");

    // Two multi-term vectors back to back
    send(1, 1, 0); send(8, 8, 0); send(15, 15, 1);
    send(127, 63, 0); send(170, 85, 1);
    idle();
    wait_drain("drain_multi");

    // Back-to-back single-term vectors
    for (int i = 0; i < 6; i++) send(i * 40 + 3, 255 - i * 30, 1);
    idle();
    wait_drain("drain_b2b");

    // Backpressure: result held, input stalled
    set_ready(1'b0);
    fork
      begin
        send(0, 0, 1); send(3, 5, 0); send(2, 2, 1); send(7, 7, 1);
        idle();
      end
      begin
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.out_valid && n < 20);
        for (int i = 0; i < 4; i++) begin
          check("stall_out_valid", bus.out_valid, 1);
          check("stall_in_ready", bus.in_ready, 0);
          check("stall_out_sum", bus.out_sum, 0);
          check("stall_out_count", bus.out_count, 1);
          @(negedge clk);
        end
        @(posedge clk); #1;
        set_ready(1'b1);
      end
    join
    wait_drain("drain_stall");

    // Overflow of the 16-bit accumulator
    send(255, 255, 0); send(255, 255, 1);
    send(255, 255, 0); send(255, 255, 0); send(0, 0, 0); send(1, 1, 1);
    idle();
    wait_drain("drain_ovf");

    // Reset mid-vector
    send(15, 15, 0); send(15, 15, 0);
    idle();
    rst = 1'b1;
    m_sum = 0; m_cnt = 0; m_ovf = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_out_sum", bus.out_sum, 0);
    check("mid_rst_out_count", bus.out_count, 0);
    check("mid_rst_out_ovf", bus.out_ovf, 0);
    check("mid_rst_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    send(1, 1, 1);
    idle();
    wait_drain("drain_rst");

    // Count saturation with a long vector
    for (int i = 0; i < 20; i++) send(i + 1, 2, i == 19);
    idle();
    wait_drain("drain_sat_cnt");

    // Randomized traffic with random backpressure
    rdy_mode = 1'b1;
    for (int i = 0; i < 400; i++) begin
      int unsigned av, bv;
      case ($urandom_range(0, 3))
        0: av = 255;
        1: av = 0;
        default: av = $urandom_range(0, 255);
      endcase
      bv = ($urandom_range(0, 2) == 0) ? 255 : $urandom_range(0, 255);
      send(av, bv, $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 4) == 0) idle();
    end
    send(9, 9, 1);
    idle();
    set_ready(1'b1);
    wait_drain("drain_random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/wallace_mac.md
# wallace_mac

Pipelined multiply-accumulate stage placed directly downstream of the `wallace` 8x8 combinational multiplier. It accepts a stream of 8-bit operand pairs over a valid/ready handshake and registers them in front of an internal `wallace` instance. It then registers the 16-bit product and sums the products of each vector, where a vector is delimited by `in_last`. Each completed sum is presented on a held output register with its own valid/ready handshake.

## Interface
- `ACC_W`, default 24: accumulator and `out_sum` width; legal range is ≥16.
- `CNT_W`, default 8: width of the per-vector term counter.
- `clk` input 1: the single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: the operand pair on `a`/`b` is valid.
- `in_ready` output 1: the block can accept a beat this cycle.
- `a` input 8: unsigned multiplicand.
- `b` input 8: unsigned multiplier.
- `in_last` input 1: this beat is the final term of the current vector.
- `out_valid` output 1: `out_sum`, `out_count` and `out_ovf` hold a completed result.
- `out_ready` input 1: the consumer accepts the result this cycle.
- `out_sum` output `ACC_W`: sum of the products of the vector.
- `out_count` output `CNT_W`: number of terms in the vector, saturating at 2^CNT_W−1.
- `out_ovf` output 1: the accumulation exceeded `ACC_W` bits at some point in the vector.

## Operation
- Beat accepted when `in_valid && in_ready`.
- Global advance: `adv = !out_valid || out_ready`. Every pipeline register updates only when `adv` is high.
- `in_ready = adv`, and it is combinational.
- **S1 (operand register):** on an accepted beat, captures `a`, `b`, `in_last` and sets `s1_v`. If `adv` is high and no beat is accepted, `s1_v` is cleared.
- **Multiply:** the `wallace` instance takes `s1_a` and `s1_b` and drives its 16-bit `asn`.
- **S2 (product register):** captures `asn`, `s1_last` and `s1_v`.
- **Accumulate:** when `s2_v` is high, `nxt = acc + s2_p`, computed at `ACC_W+1` bits.
  - The carry-out of `nxt` sets a sticky `ovf`.
  - `cnt` increments and saturates at its maximum value.
- **Vector completion** (`s2_v && s2_last`):
  - `out_sum`, `out_count` and `out_ovf` load `nxt`, `cnt+1` and `ovf|carry`.
  - `out_valid` is set.
  - `acc`, `cnt` and `ovf` clear to 0 on the same edge, so the next vector starts with no bubble.
- **Output handshake:** the result transfers when `out_valid && out_ready`. On that edge `out_valid` clears, unless a new completion loads on the same edge, in which case `out_valid` stays 1 with the new data.
- **Stall:** while `out_valid && !out_ready`, S1, S2, `acc` and the output registers all hold, and `in_ready` is 0.
- **Empty vectors:** not possible. `in_last` on the first beat produces a single-term result.
- **Reset:**
  - All valid bits, `acc`, `cnt`, `ovf`, `out_sum`, `out_count`, `out_ovf` and `out_valid` go to 0.
  - `in_ready` is 1 in the first cycle after reset.
  - Reset mid-vector discards the partial sum and any beats in flight.

## Timing
- **Latency:** beat accepted at edge E0 → S1 valid after E0 → S2 valid after E1 → accumulated at E2.
  - For a last beat, `out_valid` is high in the cycle after E2, which is 3 cycles after the cycle in which `in_valid` was sampled.
- **Throughput:** 1 beat per cycle while `out_ready` is high or no result is pending.
- **Back-to-back vectors:** vectors sent with no idle cycle produce results on consecutive cycles, provided the vectors are single-term and `out_ready` is held at 1.
- **Critical path:** the S1 registers through the `wallace` tree into S2. The accumulator adder sits in its own stage.

## Configuration
- **`WALLACE_MAC_SATURATE_EN` defined:** when the carry-out is set, `acc`/`out_sum` clamp to 2^ACC_W−1. Later terms in the same vector keep the value clamped. `out_ovf` is still reported.
- **`WALLACE_MAC_SATURATE_EN` undefined:** the sum wraps modulo 2^ACC_W, and `out_ovf` flags the wrap.

## Test plan
- **Single term:** send 255×255 with `in_last=1` and `out_ready=1`.
  - Required: `out_sum`=65025, `out_count`=1, `out_ovf`=0.
  - Required: `out_valid` is high exactly 3 cycles after the beat is sampled, for 1 cycle.
- **Multi-term vector:** send {1×1, 8×8, 15×15 (last)} back-to-back.
  - Required: `out_sum`=290, `out_count`=3.
  - Then send {127×63, 170×85 (last)}; required: `out_sum`=22451, `out_count`=2, with no bubble between the two vectors.
- **Backpressure:** send a vector {0×0 (last)} and hold `out_ready`=0 for 4 cycles.
  - Required: `in_ready`=0 and the result held at `out_sum`=0, `out_count`=1.
  - Required: beats presented on the input during the stall are not accepted.
  - After `out_ready` is raised, required: the next queued result follows in order.
- **Overflow (ACC_W=16):** send {255×255, 255×255 (last)}.
  - Required without the macro: `out_sum`=64514, `out_ovf`=1.
  - Required with `WALLACE_MAC_SATURATE_EN`: `out_sum`=65535, `out_ovf`=1.
- **Reset mid-vector:** send 2 beats of 15×15 without `in_last`, then pulse `rst` for 1 cycle, then send 1×1 (last).
  - Required: `out_sum`=1, `out_count`=1, `out_ovf`=0.
  - Required: all outputs are 0 during reset.
